// File: rtl/mm_stream_pkg.sv
// rtl/mm_stream_pkg.sv - shared state type and default sizing for mm_stream_master
package mm_stream_pkg;

  localparam int MM_K_DEFAULT       = 128;
  localparam int MM_N_DEFAULT       = 16;
  localparam int MM_TIMEOUT_DEFAULT = 65536;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_Y   = 3'd1,
    START    = 3'd2,
    LOAD_X   = 3'd3,
    WAIT_RES = 3'd4,
    RESP     = 3'd5
  } mm_state_e;

endpackage

// File: rtl/mm_word_shift.sv
// rtl/mm_word_shift.sv - parallel-load operand register presenting one K-bit word per shift step
module mm_word_shift #(
  parameter int K = 128,
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [K*N-1:0] load_data,
  input  logic           shift,
  output logic [K-1:0]   word
);

  logic [K*N-1:0] sr;

  // Word 0 sits in the LSBs, so shifting right walks the operand low word first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (shift) begin
      sr <= {{K{1'b0}}, sr[K*N-1:K]};
    end
  end

  assign word = sr[K-1:0];

endmodule

// File: rtl/mm_stream_master.sv
// rtl/mm_stream_master.sv - streams y then x to a Montgomery core and assembles its N-word result
// Optional WAIT_RES watchdog enabled by defining MM_STREAM_TIMEOUT_EN.
module mm_stream_master
  import mm_stream_pkg::*;
#(
  parameter int K              = MM_K_DEFAULT,
  parameter int N              = MM_N_DEFAULT,
  parameter int TIMEOUT_CYCLES = MM_TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [K*N-1:0] req_x,
  input  logic [K*N-1:0] req_y,
  output logic           mm_start,
  output logic [K-1:0]   mm_x,
  output logic           mm_x_valid,
  output logic [K-1:0]   mm_y,
  output logic           mm_y_valid,
  input  logic [K-1:0]   mm_result,
  input  logic           mm_valid,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [K*N-1:0] rsp_data,
  output logic           rsp_err,
  output logic           busy
);

  localparam int            CW   = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mm_state_e      state, state_nx;
  logic [CW-1:0]  cnt;
  logic [K*N-1:0] res_q;
  logic [K-1:0]   x_word, y_word;
  logic           accept, capture, done, timeout;

  assign accept  = req_valid && (state == IDLE);
  assign capture = (state == WAIT_RES) && mm_valid && (cnt < CW'(N));
  assign done    = capture && (cnt == LAST);

  mm_word_shift #(.K(K), .N(N)) u_shift_y (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data (req_y),
    .shift     (state == LOAD_Y),
    .word      (y_word)
  );

  mm_word_shift #(.K(K), .N(N)) u_shift_x (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data (req_x),
    .shift     (state == LOAD_X),
    .word      (x_word)
  );

`ifdef MM_STREAM_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd;
  logic          err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd    <= '0;
      err_q <= 1'b0;
    end else begin
      wd <= (state == WAIT_RES) ? wd + WW'(1) : '0;
      if (accept) begin
        err_q <= 1'b0;
      end else if (timeout && !done) begin
        err_q <= 1'b1;
      end
    end
  end

  assign timeout = (state == WAIT_RES) && (wd == WW'(TIMEOUT_CYCLES - 1));
  assign rsp_err = (state == RESP) && err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = LOAD_Y;
      LOAD_Y:   if (cnt == LAST) state_nx = START;
      START:    state_nx = LOAD_X;
      LOAD_X:   if (cnt == LAST) state_nx = WAIT_RES;
      WAIT_RES: if (done || timeout) state_nx = RESP;
      RESP:     if (rsp_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // One counter serves both load phases and result capture; any state change restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      res_q <= '0;
    end else begin
      if (state_nx != state) begin
        cnt <= '0;
      end else if ((state == LOAD_Y) || (state == LOAD_X) || capture) begin
        cnt <= cnt + CW'(1);
      end

      if (accept || (timeout && !done)) begin
        res_q <= '0;
      end else if (capture) begin
        for (int i = 0; i < N; i++) begin
          if (cnt == CW'(i)) res_q[i*K +: K] <= mm_result;
        end
      end
    end
  end

  always_comb begin
    req_ready  = rst_n && (state == IDLE);
    busy       = (state != IDLE);
    mm_start   = (state == START);
    mm_y_valid = (state == LOAD_Y);
    mm_x_valid = (state == LOAD_X);
    mm_y       = '0;
    mm_x       = '0;
    rsp_valid  = (state == RESP);
    rsp_data   = '0;
    if (state == LOAD_Y) mm_y = y_word;
    if (state == LOAD_X) mm_x = x_word;
    if (state == RESP)   rsp_data = res_q;
  end

endmodule

// File: tb/tb_mm_stream_master.sv
// tb/tb_mm_stream_master.sv - directed scoreboard bench for mm_stream_master
module tb_mm_stream_master;

  localparam int K  = 32;
  localparam int N  = 8;
  localparam int TO = 64;
  localparam int W  = K * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_x = '0;
  logic [W-1:0] req_y = '0;
  logic         mm_start;
  logic [K-1:0] mm_x, mm_y;
  logic         mm_x_valid, mm_y_valid;
  logic [K-1:0] mm_result = '0;
  logic         mm_valid = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [K-1:0] xq[$], yq[$], rq[$];
  logic [W-1:0] exp_data;

  mm_stream_master #(.K(K), .N(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .mm_start   (mm_start),
    .mm_x       (mm_x),
    .mm_x_valid (mm_x_valid),
    .mm_y       (mm_y),
    .mm_y_valid (mm_y_valid),
    .mm_result  (mm_result),
    .mm_valid   (mm_valid),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_k(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Seed 0 gives x=i+1, y=0x100+i and core results 0xA0+i.
  task automatic push_req(input int seed);
    logic [K-1:0] wx, wy, wr;
    for (int i = 0; i < N; i++) begin
      wx = K'(seed * 32'h1000 + i + 1);
      wy = K'(seed * 32'h1000 + 32'h100 + i);
      wr = K'(seed * 32'h10000 + 32'hA0 + i);
      req_x[i*K +: K] = wx;
      req_y[i*K +: K] = wy;
      xq.push_back(wx);
      yq.push_back(wy);
      rq.push_back(wr);
    end
    req_valid = 1'b1;
  endtask

  task automatic accept_req(input int seed);
    push_req(seed);
    chk_b("req_ready_idle", req_ready, 1'b1);
    tick;
    req_valid = 1'b0;
  endtask

  task automatic check_load(input int abort_at, input bit junk);
    for (int i = 0; i < N; i++) begin
      chk_b("y_valid", mm_y_valid, 1'b1);
      chk_k("y_word", mm_y, yq.pop_front());
      chk_b("x_valid_in_y", mm_x_valid, 1'b0);
      chk_b("req_ready_busy", req_ready, 1'b0);
      tick;
    end
    chk_b("start_pulse", mm_start, 1'b1);
    chk_b("y_valid_off", mm_y_valid, 1'b0);
    chk_k("y_zero", mm_y, '0);
    tick;
    for (int i = 0; i < N; i++) begin
      if (i == abort_at) return;
      chk_b("start_off", mm_start, 1'b0);
      chk_b("x_valid", mm_x_valid, 1'b1);
      chk_k("x_word", mm_x, xq.pop_front());
      mm_valid  = junk;
      mm_result = K'(32'hDEAD0000 + i);
      tick;
    end
    mm_valid  = 1'b0;
    mm_result = '0;
    chk_b("x_valid_off", mm_x_valid, 1'b0);
    chk_k("x_zero", mm_x, '0);
    chk_b("busy_wait", busy, 1'b1);
  endtask

  task automatic feed(input int gap, input int nwords);
    logic [K-1:0] w;
    exp_data = '0;
    for (int i = 0; i < nwords; i++) begin
      w = rq.pop_front();
      exp_data[i*K +: K] = w;
      mm_valid  = 1'b1;
      mm_result = w;
      tick;
      mm_valid  = 1'b0;
      mm_result = '0;
      if (i != nwords - 1) begin
        for (int g = 0; g < gap; g++) begin
          chk_b("no_rsp_during_gap", rsp_valid, 1'b0);
          tick;
        end
      end
    end
  endtask

  task automatic check_resp(input int hold, input int next_seed, input logic err);
    chk_b("rsp_valid", rsp_valid, 1'b1);
    chk_b("rsp_err", rsp_err, err);
    chk_w("rsp_data", rsp_data, exp_data);
    for (int h = 0; h < hold; h++) begin
      mm_valid  = 1'b1;
      mm_result = K'(32'hBAD0 + h);
      tick;
      chk_b("rsp_valid_hold", rsp_valid, 1'b1);
      chk_w("rsp_data_hold", rsp_data, exp_data);
      chk_b("req_ready_hold", req_ready, 1'b0);
    end
    mm_valid  = 1'b0;
    mm_result = '0;
    rsp_ready = 1'b1;
    if (next_seed >= 0) push_req(next_seed);
    tick;
    chk_b("rsp_valid_drop", rsp_valid, 1'b0);
    chk_b("req_ready_after", req_ready, 1'b1);
    chk_b("busy_after", busy, 1'b0);
    chk_b("y_valid_idle", mm_y_valid, 1'b0);
    if (next_seed >= 0) begin
      tick;
      req_valid = 1'b0;
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    tick;
    tick;
    chk_b("rst_req_ready", req_ready, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_rsp_valid", rsp_valid, 1'b0);
    chk_b("rst_start", mm_start, 1'b0);
    chk_w("rst_rsp_data", rsp_data, '0);
    rst_n = 1'b1;
    tick;
    chk_b("idle_req_ready", req_ready, 1'b1);
    chk_b("idle_busy", busy, 1'b0);

    // Reference pattern with a 10-cycle response stall.
    accept_req(0);
    check_load(-1, 1'b0);
    feed(0, N);
    check_resp(10, -1, 1'b0);

    // Gapped results, stray pulses in LOAD_X and after word N, then back-to-back.
    accept_req(1);
    check_load(-1, 1'b1);
    feed(2, N);
    check_resp(2, 2, 1'b0);
    check_load(-1, 1'b0);
    feed(0, N);
    check_resp(0, -1, 1'b0);

    // Reset in LOAD_X cycle 5 discards the transaction.
    accept_req(3);
    check_load(5, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_b("abort_x_valid", mm_x_valid, 1'b0);
    chk_k("abort_x", mm_x, '0);
    chk_b("abort_busy", busy, 1'b0);
    chk_b("abort_req_ready", req_ready, 1'b0);
    chk_b("abort_rsp_valid", rsp_valid, 1'b0);
    chk_w("abort_rsp_data", rsp_data, '0);
    xq.delete();
    yq.delete();
    rq.delete();
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk_b("post_abort_rsp_valid", rsp_valid, 1'b0);
    chk_b("post_abort_ready", req_ready, 1'b1);
    accept_req(4);
    check_load(-1, 1'b0);
    feed(0, N);
    check_resp(1, -1, 1'b0);

`ifdef MM_STREAM_TIMEOUT_EN
    // Core returns only 3 words; RESP must appear at WAIT_RES cycle TO.
    accept_req(5);
    check_load(-1, 1'b0);
    feed(0, 3);
    rq.delete();
    for (int c = 3; c < TO - 1; c++) tick;
    chk_b("timeout_not_yet", rsp_valid, 1'b0);
    chk_b("timeout_busy", busy, 1'b1);
    tick;
    exp_data = '0;
    check_resp(0, -1, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
